// File: rtl/coefficient_codec_pkg.sv
// Shared definitions for the JPEG coefficient magnitude codec (EXTEND side).
package coefficient_codec_pkg;

  localparam int DEFAULT_COEF_WIDTH = 16;
  localparam int DEFAULT_LEN_WIDTH  = 4;

  // Largest legal magnitude category for the default coefficient width.
  localparam int MAX_CATEGORY = DEFAULT_COEF_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    OUTPUT = 2'd2
  } dec_state_e;

endpackage : coefficient_codec_pkg

// File: rtl/coefficient_extend.sv
// EXTEND: maps an L-bit appended field V back to its signed coefficient.
// Positive values are sent verbatim; negative values are sent as V + (2^L - 1),
// so a cleared MSB means the field must be re-biased by -(2^L - 1).
module coefficient_extend
  import coefficient_codec_pkg::*;
#(
  parameter int COEF_WIDTH = DEFAULT_COEF_WIDTH,
  parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
  input  logic        [COEF_WIDTH-2:0] v_i,
  input  logic        [LEN_WIDTH-1:0]  l_i,
  output logic signed [COEF_WIDTH-1:0] coef_o
);

  logic [COEF_WIDTH-1:0] v_ext;
  logic [COEF_WIDTH-1:0] pow;
  logic [COEF_WIDTH-1:0] mask;
  logic [COEF_WIDTH-1:0] v_masked;
  logic                  msb;

  // Arithmetic is modulo 2^COEF_WIDTH: identical to a wider subtraction
  // followed by truncation, and L never exceeds COEF_WIDTH-1 so 2^L fits.
  assign v_ext    = {1'b0, v_i};
  assign pow      = COEF_WIDTH'(1) << l_i;
  assign mask     = pow - COEF_WIDTH'(1);
  assign v_masked = v_ext & mask;
  // pow >> 1 selects bit L-1; it is zero for L == 0, giving a result of 0.
  assign msb      = |(v_masked & (pow >> 1));
  assign coef_o   = msb ? v_masked : (v_masked - mask);

endmodule : coefficient_extend

// File: rtl/coefficient_decoder.sv
// Serial coefficient decoder: takes a magnitude category, consumes that many
// scan bits MSB first, and presents the reconstructed signed coefficient.
module coefficient_decoder
  import coefficient_codec_pkg::*;
#(
  parameter int COEF_WIDTH = DEFAULT_COEF_WIDTH,
  parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         len_valid,
  output logic                         len_ready,
  input  logic        [LEN_WIDTH-1:0]  len_in,
  input  logic                         bit_valid,
  output logic                         bit_ready,
  input  logic                         bit_in,
  output logic                         coef_valid,
  input  logic                         coef_ready,
  output logic signed [COEF_WIDTH-1:0] coefficient
);

  localparam int SW      = COEF_WIDTH - 1;
  localparam int MAX_LEN = COEF_WIDTH - 1;

  dec_state_e                  state_q, state_d;
  logic        [LEN_WIDTH-1:0] len_q, len_d;
  logic        [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic        [SW-1:0]        shift_q, shift_d;
  logic signed [COEF_WIDTH-1:0] coef_q, coef_d;
  logic                        len_ready_q, len_ready_d;
  logic                        bit_ready_q, bit_ready_d;
  logic                        coef_valid_q, coef_valid_d;
  logic        [LEN_WIDTH-1:0] len_clamped;
  logic signed [COEF_WIDTH-1:0] ext_coef;

  // Out-of-range categories are clamped; only needed when LEN_WIDTH can
  // express values above COEF_WIDTH-1.
  if ((2 ** LEN_WIDTH - 1) > MAX_LEN) begin : g_clamp
    assign len_clamped = (len_in > LEN_WIDTH'(MAX_LEN)) ? LEN_WIDTH'(MAX_LEN) : len_in;
  end else begin : g_no_clamp
    assign len_clamped = len_in;
  end

  // Reconstruct from the shift register including the bit arriving now.
  coefficient_extend #(
    .COEF_WIDTH (COEF_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_extend (
    .v_i    (shift_d),
    .l_i    (len_q),
    .coef_o (ext_coef)
  );

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      shift_q      <= '0;
      coef_q       <= '0;
      len_ready_q  <= 1'b1;
      bit_ready_q  <= 1'b0;
      coef_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      coef_q       <= coef_d;
      len_ready_q  <= len_ready_d;
      bit_ready_q  <= bit_ready_d;
      coef_valid_q <= coef_valid_d;
    end
  end

  // Next state and datapath updates driven by the three handshakes.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    coef_d  = coef_q;
    unique case (state_q)
      IDLE: begin
        if (len_valid && len_ready_q) begin
          len_d   = len_clamped;
          cnt_d   = len_clamped;
          shift_d = '0;
          if (len_clamped == '0) begin
            coef_d  = '0;
            state_d = OUTPUT;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (bit_valid && bit_ready_q) begin
          shift_d = {shift_q[SW-2:0], bit_in};
          cnt_d   = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) begin
            coef_d  = ext_coef;
            state_d = OUTPUT;
          end
        end
      end
      OUTPUT: begin
        if (coef_ready && coef_valid_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the next state, then registered.
  always_comb begin
    len_ready_d  = (state_d == IDLE);
    bit_ready_d  = (state_d == SHIFT);
    coef_valid_d = (state_d == OUTPUT);
  end

  assign len_ready   = len_ready_q;
  assign bit_ready   = bit_ready_q;
  assign coef_valid  = coef_valid_q;
  assign coefficient = coef_q;

endmodule : coefficient_decoder
